// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its RAM.
package dmem_pkg;

  localparam int unsigned WORD_LSB = 2;
  localparam int unsigned LANE_W   = 8;
  localparam int unsigned LANES    = 4;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Byte-lane write enables: one lane for byte stores, all four for word stores.
  function automatic logic [LANES-1:0] lane_mask(input logic is_byte, input logic [1:0] lane);
    return is_byte ? (LANES'(1) << lane) : {LANES{1'b1}};
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the memory stage and the responder.
interface dmem_responder_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 data RAM: synchronous byte-masked write, combinational read, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic [LANES-1:0]         we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int unsigned l = 0; l < LANES; l++) begin
      if (we_i[l]) begin
        mem_q[addr_i][l*LANE_W +: LANE_W] <= wdata_i[l*LANE_W +: LANE_W];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed wait-state latency,
// word/byte access to a local RAM with alignment and range checking.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned       IdxW      = $clog2(DEPTH);
  localparam int unsigned       WordW     = ADDR_W - WORD_LSB;
  localparam logic [WordW-1:0]  WordLimit = WordW'(DEPTH);
  localparam logic [CNT_W-1:0]  CntInit   = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_we_q;
  logic               req_byte_q;
  logic [ADDR_W-1:0]  req_addr_q;
  logic [31:0]        req_wdata_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               accept;
  logic               commit;

  logic [WordW-1:0]   word_sel;
  logic [IdxW-1:0]    idx;
  logic [1:0]         lane;
  logic               misaligned;
  logic               out_of_range;
  logic               req_err;
  logic [31:0]        ram_rdata;
  logic [31:0]        ram_wdata;
  logic [31:0]        load_data;
  logic [LANES-1:0]   ram_we;

  // Decode of the latched request; only meaningful while a request is held.
  assign word_sel     = req_addr_q[ADDR_W-1:WORD_LSB];
  assign idx          = req_addr_q[WORD_LSB +: IdxW];
  assign lane         = req_addr_q[WORD_LSB-1:0];
  assign misaligned   = !req_byte_q && (lane != 2'b00);
  assign out_of_range = (word_sel >= WordLimit);
  assign req_err      = misaligned || out_of_range;

  assign load_data = req_byte_q ? {24'b0, ram_rdata[lane*LANE_W +: LANE_W]} : ram_rdata;
  assign ram_wdata = req_byte_q ? {LANES{req_wdata_q[LANE_W-1:0]}} : req_wdata_q;
  assign ram_we    = (commit && req_we_q && !req_err) ? lane_mask(req_byte_q, lane) : '0;

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (idx),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  // LATENCY==1 still spends one cycle in StWait (counter 0), so rsp_valid
  // always rises exactly LATENCY edges after the accepting edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = CntInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = StResp;
          err_d   = req_err;
          rdata_d = (req_err || req_we_q) ? '0 : load_data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      req_we_q    <= 1'b0;
      req_byte_q  <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        req_we_q    <= bus.req_we;
        req_byte_q  <= bus.req_byte;
        req_addr_q  <= bus.req_addr;
        req_wdata_q <= bus.req_wdata;
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance share one driver,
// a transaction-level model is compared against both every cycle.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;

  logic clk;
  logic reset;

  dmem_responder_if #(.ADDR_W(32)) bus_a ();
  dmem_responder_if #(.ADDR_W(32)) bus_b ();

  dmem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .LATENCY(2)) u_dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  dmem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .LATENCY(1)) u_dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  int          sel;
  logic        drv_valid, drv_we, drv_byte, drv_rsp_ready;
  logic [31:0] drv_addr, drv_wdata;

  assign bus_a.req_valid = drv_valid && (sel == 0);
  assign bus_b.req_valid = drv_valid && (sel == 1);
  assign bus_a.req_we    = drv_we;
  assign bus_b.req_we    = drv_we;
  assign bus_a.req_byte  = drv_byte;
  assign bus_b.req_byte  = drv_byte;
  assign bus_a.req_addr  = drv_addr;
  assign bus_b.req_addr  = drv_addr;
  assign bus_a.req_wdata = drv_wdata;
  assign bus_b.req_wdata = drv_wdata;
  assign bus_a.rsp_ready = drv_rsp_ready;
  assign bus_b.rsp_ready = drv_rsp_ready;

  logic [1:0]  obs_ready, obs_valid, obs_err;
  logic [31:0] obs_rdata [2];
  assign obs_ready    = {bus_b.req_ready, bus_a.req_ready};
  assign obs_valid    = {bus_b.rsp_valid, bus_a.rsp_valid};
  assign obs_err      = {bus_b.rsp_err, bus_a.rsp_err};
  assign obs_rdata[0] = bus_a.rsp_rdata;
  assign obs_rdata[1] = bus_b.rsp_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          lat_of [2] = '{2, 1};
  bit          m_pend [2];
  bit          m_resp [2];
  int          m_age  [2];
  bit          m_we   [2];
  bit          m_bt   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd   [2];
  logic [31:0] m_rdata[2];
  bit          m_err  [2];
  bit          m_rknown[2];
  bit [31:0]   mem_m  [2][DEPTH];
  bit [3:0]    kn_m   [2][DEPTH];

  task automatic model_respond(input int d);
    int unsigned idx, ln;
    bit          err;
    idx = m_addr[d] >> 2;
    ln  = m_addr[d] % 4;
    err = (!m_bt[d] && ln != 0) || (idx >= DEPTH);
    m_resp[d]   = 1'b1;
    m_err[d]    = err;
    m_rdata[d]  = 32'h0;
    m_rknown[d] = 1'b1;
    if (err) begin
    end else if (m_we[d]) begin
      if (m_bt[d]) begin
        mem_m[d][idx] = (mem_m[d][idx] & ~(32'hFF << (8 * ln))) | ((m_wd[d] & 32'hFF) << (8 * ln));
        kn_m[d][idx][ln] = 1'b1;
      end else begin
        mem_m[d][idx] = m_wd[d];
        kn_m[d][idx]  = 4'hF;
      end
    end else if (m_bt[d]) begin
      m_rdata[d]  = (mem_m[d][idx] >> (8 * ln)) & 32'hFF;
      m_rknown[d] = kn_m[d][idx][ln];
    end else begin
      m_rdata[d]  = mem_m[d][idx];
      m_rknown[d] = (kn_m[d][idx] == 4'hF);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 1'b0;
      m_resp[d] = 1'b0;
      m_age[d]  = 0;
    end
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int d = 0; d < 2; d++) begin
          m_pend[d] = 1'b0;
          m_resp[d] = 1'b0;
          m_age[d]  = 0;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (m_resp[d]) begin
            if (drv_rsp_ready) begin
              m_resp[d] = 1'b0;
              m_pend[d] = 1'b0;
            end
          end else if (m_pend[d]) begin
            m_age[d]++;
            if (m_age[d] == lat_of[d]) model_respond(d);
          end else if (drv_valid && sel == d) begin
            m_pend[d] = 1'b1;
            m_age[d]  = 0;
            m_we[d]   = drv_we;
            m_bt[d]   = drv_byte;
            m_addr[d] = drv_addr;
            m_wd[d]   = drv_wdata;
          end
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk(d ? "b.req_ready" : "a.req_ready", 32'(obs_ready[d]), 32'(!m_pend[d]));
        chk(d ? "b.rsp_valid" : "a.rsp_valid", 32'(obs_valid[d]), 32'(m_resp[d]));
        if (m_resp[d]) begin
          chk(d ? "b.rsp_err" : "a.rsp_err", 32'(obs_err[d]), 32'(m_err[d]));
          if (m_rknown[d]) chk(d ? "b.rsp_rdata" : "a.rsp_rdata", obs_rdata[d], m_rdata[d]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic xact(input bit we, input bit bt, input logic [31:0] a, input logic [31:0] wd,
                      input int hold, input bit keep, output logic [31:0] rd, output logic er,
                      output int lat, output int accw);
    drv_we        = we;
    drv_byte      = bt;
    drv_addr      = a;
    drv_wdata     = wd;
    drv_valid     = 1'b1;
    drv_rsp_ready = 1'b0;
    rd   = '0;
    er   = 1'b0;
    lat  = 0;
    accw = 0;
    while (!obs_ready[sel] && accw < 40) begin
      @(posedge clk); #1;
      accw++;
    end
    if (!obs_ready[sel]) begin
      chk("accept_timeout", 32'(obs_ready[sel]), 32'h1);
      drv_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!keep) drv_valid = 1'b0;
    while (!obs_valid[sel] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!obs_valid[sel]) begin
      chk("rsp_timeout", 32'(obs_valid[sel]), 32'h1);
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    drv_rsp_ready = 1'b1;
    rd = obs_rdata[sel];
    er = obs_err[sel];
    @(posedge clk); #1;
    drv_rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, accw;

    reset = 1'b1;
    sel = 0;
    drv_valid = 1'b0; drv_we = 1'b0; drv_byte = 1'b0; drv_rsp_ready = 1'b0;
    drv_addr = '0; drv_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(obs_ready[0]), 32'h1);
    chk("rst_rsp_valid", 32'(obs_valid[0]), 32'h0);
    chk("rst_rdata", obs_rdata[0], 32'h0);
    chk("rst_err", 32'(obs_err[0]), 32'h0);
    reset = 1'b0;

    // Word store then load, latency 2.
    xact(1, 0, 32'h10, 32'hDEADBEEF, 0, 0, rd, er, lat, accw);
    chk("st_word_rdata", rd, 32'h0);
    chk("st_word_err", 32'(er), 32'h0);
    chk("st_word_lat", lat, 2);
    xact(0, 0, 32'h10, 32'h0, 0, 0, rd, er, lat, accw);
    chk("ld_word_rdata", rd, 32'hDEADBEEF);
    chk("ld_word_lat", lat, 2);

    // Byte store into lane 2, word and byte reload.
    xact(1, 1, 32'h12, 32'h000000A5, 0, 0, rd, er, lat, accw);
    chk("st_byte_err", 32'(er), 32'h0);
    xact(0, 0, 32'h10, 32'h0, 0, 0, rd, er, lat, accw);
    chk("ld_after_sb", rd, 32'hDEA5BEEF);
    xact(0, 1, 32'h13, 32'h0, 0, 0, rd, er, lat, accw);
    chk("ld_byte_lane3", rd, 32'h000000DE);

    // Errors: misaligned word load, out-of-range store must not alias idx 0.
    xact(1, 0, 32'h0, 32'h12345678, 0, 0, rd, er, lat, accw);
    xact(0, 0, 32'h6, 32'h0, 0, 0, rd, er, lat, accw);
    chk("misalign_err", 32'(er), 32'h1);
    chk("misalign_rdata", rd, 32'h0);
    xact(1, 0, 32'h100, 32'hFFFFFFFF, 0, 0, rd, er, lat, accw);
    chk("oor_err", 32'(er), 32'h1);
    chk("oor_rdata", rd, 32'h0);
    xact(0, 0, 32'h0, 32'h0, 0, 0, rd, er, lat, accw);
    chk("idx0_unchanged", rd, 32'h12345678);

    // Backpressure with req_valid held through RESP.
    xact(1, 0, 32'h20, 32'h11111111, 0, 0, rd, er, lat, accw);
    xact(0, 0, 32'h20, 32'h0, 5, 1, rd, er, lat, accw);
    chk("bp_rdata", rd, 32'h11111111);
    chk("bp_ready_after_hs", 32'(obs_ready[0]), 32'h1);
    xact(0, 1, 32'h21, 32'h0, 0, 0, rd, er, lat, accw);
    chk("bp_next_accw", accw, 0);
    chk("bp_next_lat", lat, 2);
    chk("bp_next_rdata", rd, 32'h00000011);

    // Reset during WAIT of a store drops it.
    drv_we = 1'b1; drv_byte = 1'b0; drv_addr = 32'h20; drv_wdata = 32'h22222222;
    drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    chk("wait_req_ready", 32'(obs_ready[0]), 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_req_ready", 32'(obs_ready[0]), 32'h1);
    chk("midrst_rsp_valid", 32'(obs_valid[0]), 32'h0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    xact(0, 0, 32'h20, 32'h0, 0, 0, rd, er, lat, accw);
    chk("midrst_no_write", rd, 32'h11111111);

    // LATENCY=1 instance: back-to-back stores to consecutive words.
    sel = 1;
    for (int i = 0; i < 4; i++) begin
      xact(1, 0, 32'(4 * i), 32'hA0A00000 + 32'(i), 0, (i < 3), rd, er, lat, accw);
      chk("l1_st_lat", lat, 1);
      if (i > 0) chk("l1_st_accw", accw, 0);
    end
    drv_valid = 1'b0;
    xact(0, 0, 32'h0, 32'h0, 0, 0, rd, er, lat, accw);
    chk("l1_ld0", rd, 32'hA0A00000);
    xact(0, 0, 32'h8, 32'h0, 0, 0, rd, er, lat, accw);
    chk("l1_ld2", rd, 32'hA0A00002);
    xact(0, 0, 32'hC, 32'h0, 0, 0, rd, er, lat, accw);
    chk("l1_ld3", rd, 32'hA0A00003);
    xact(1, 1, 32'h5, 32'h00000077, 0, 0, rd, er, lat, accw);
    xact(0, 0, 32'h4, 32'h0, 0, 0, rd, er, lat, accw);
    chk("l1_ld1_sb", rd, 32'hA0A07701);
    chk("l1_ld_lat", lat, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
